// File: rtl/usb_pkg.sv
// Shared USB constants, CRC16 parameters and the IN endpoint state encoding.
package usb_pkg;

   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;
   localparam logic [7:0] PID_ACK   = 8'hD2;
   localparam logic [7:0] PID_NAK   = 8'h5A;
   localparam logic [7:0] PID_STALL = 8'h1E;

   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HS       = 3'd1,
      ST_PID      = 3'd2,
      ST_PAYLOAD  = 3'd3,
      ST_CRC_LO   = 3'd4,
      ST_CRC_HI   = 3'd5,
      ST_WAIT_ACK = 3'd6
   } ep_state_e;

   // USB shifts bits LSB-first, so the CRC register runs with the mirrored polynomial.
   function automatic logic [15:0] bit_rev16(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[15-i];
      return r;
   endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide reflected USB CRC16 (poly 0x8005, LSB-first); init has priority over enable.
module usb_crc16
   import usb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [15:0] crc_o
);

   localparam logic [15:0] POLY_R = bit_rev16(CRC16_POLY);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
      logic [15:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ POLY_R;
         else             c = c >> 1;
      end
      return c;
   endfunction

   always_comb begin
      crc_d = crc_q;
      if (init_i)    crc_d = CRC16_INIT;
      else if (en_i) crc_d = crc_byte(crc_q, data_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) crc_q <= CRC16_INIT;
      else     crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/ep1_in_endpoint.sv
// USB interrupt IN endpoint 1: report buffer, DATA0/1 + CRC16 sender, NAK, ACK wait with retry.
// Optional feature macro EP1_STALL_EN adds a halt input that answers IN tokens with STALL.
module ep1_in_endpoint
   import usb_pkg::*;
#(
   parameter int MAX_PKT     = 8,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] wr_data,
   input  logic [5:0] wr_addr,
   input  logic       wr_en,
   input  logic       tx_req,
   output logic       tx_done_tgl,
   input  logic       in_token,
   input  logic       ack_rcvd,
   input  logic       toggle_clr,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       tx_last,
   input  logic       tx_ready,
`ifdef EP1_STALL_EN
   input  logic       halt,
`endif
   output ep_state_e  dbg_state_o
);

   localparam int AW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(MAX_PKT - 1);
   localparam logic [CW-1:0] TIMEOUT  = CW'(ACK_TIMEOUT);

   ep_state_e   state_q, state_d;
   logic [7:0]  pkt_buf_q [MAX_PKT];
   logic [AW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        toggle_q, toggle_d;
   logic        pid_q, pid_d;
   logic        stall_q, stall_d;
   logic        done_q, done_d;
   logic [15:0] crc;
   logic        halt_w;
   logic        accept;
   logic        buf_wr_ok;

`ifdef EP1_STALL_EN
   assign halt_w = halt;
`else
   assign halt_w = 1'b0;
`endif

   // Stream handshake: a byte transfers on every clk where tx_valid & tx_ready; while
   // tx_valid is high and tx_ready low, tx_data and tx_last hold their values.
   assign accept = tx_valid & tx_ready;

   // Payload is frozen while any byte of a DATA packet is on the wire.
   always_comb begin
      buf_wr_ok = wr_en && ({1'b0, wr_addr} < 7'(MAX_PKT)) &&
                  (state_q == ST_IDLE || state_q == ST_HS || state_q == ST_WAIT_ACK);
   end

   always_ff @(posedge clk) begin
      if (buf_wr_ok) pkt_buf_q[wr_addr[AW-1:0]] <= wr_data;
   end

   usb_crc16 u_crc (
      .clk    (clk),
      .rst    (rst),
      .init_i (state_q == ST_PID),
      .en_i   (state_q == ST_PAYLOAD && accept),
      .data_i (tx_data),
      .crc_o  (crc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (in_token) state_d = (halt_w || !tx_req) ? ST_HS : ST_PID;
         end
         ST_HS:       if (accept) state_d = ST_IDLE;
         ST_PID:      if (accept) state_d = ST_PAYLOAD;
         ST_PAYLOAD:  if (accept && idx_q == LAST_IDX) state_d = ST_CRC_LO;
         ST_CRC_LO:   if (accept) state_d = ST_CRC_HI;
         ST_CRC_HI:   if (accept) state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: if (ack_rcvd || cnt_q == TIMEOUT) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      tx_data  = 8'h00;
      case (state_q)
         ST_HS: begin
            tx_valid = 1'b1;
            tx_last  = 1'b1;
            tx_data  = stall_q ? PID_STALL : PID_NAK;
         end
         ST_PID: begin
            tx_valid = 1'b1;
            tx_data  = pid_q ? PID_DATA1 : PID_DATA0;
         end
         ST_PAYLOAD: begin
            tx_valid = 1'b1;
            tx_data  = pkt_buf_q[idx_q];
         end
         ST_CRC_LO: begin
            tx_valid = 1'b1;
            tx_data  = ~crc[7:0];
         end
         ST_CRC_HI: begin
            tx_valid = 1'b1;
            tx_last  = 1'b1;
            tx_data  = ~crc[15:8];
         end
         default: ;
      endcase
   end

   // The PID is latched at the token so a toggle clear mid-packet cannot change it.
   always_comb begin
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      toggle_d = toggle_q;
      pid_d    = pid_q;
      stall_d  = stall_q;
      done_d   = done_q;
      if (state_q == ST_IDLE && in_token) begin
         idx_d   = '0;
         stall_d = halt_w;
         pid_d   = toggle_clr ? 1'b0 : toggle_q;
      end
      if (state_q == ST_PAYLOAD && accept && idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
      if (state_q == ST_CRC_HI && accept) cnt_d = '0;
      else if (state_q == ST_WAIT_ACK && cnt_q != TIMEOUT) cnt_d = cnt_q + 1'b1;
      if (state_q == ST_HS && accept && !stall_q) done_d = ~done_q;
      if (state_q == ST_WAIT_ACK && ack_rcvd) begin
         done_d   = ~done_q;
         toggle_d = ~toggle_q;
      end
      if (toggle_clr) toggle_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q    <= '0;
         cnt_q    <= '0;
         toggle_q <= 1'b0;
         pid_q    <= 1'b0;
         stall_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         toggle_q <= toggle_d;
         pid_q    <= pid_d;
         stall_q  <= stall_d;
         done_q   <= done_d;
      end
   end

   assign tx_done_tgl = done_q;
   assign dbg_state_o = state_q;

endmodule
